// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, ALUOP encodings and the multiplier FSM states.
// ALU control, the ALU and the multiplier import this so MULT_OP is defined once.
package alu_pkg;

   localparam logic [3:0] AND_OP  = 4'd0;
   localparam logic [3:0] OR_OP   = 4'd1;
   localparam logic [3:0] ADD_OP  = 4'd2;
   localparam logic [3:0] SLL_OP  = 4'd3;
   localparam logic [3:0] SRL_OP  = 4'd4;
   localparam logic [3:0] SUB_OP  = 4'd6;
   localparam logic [3:0] SLT_OP  = 4'd7;
   localparam logic [3:0] MULT_OP = 4'd8;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mult_state_e;

   function automatic logic is_mult(input logic [3:0] ctrl);
      return ctrl == MULT_OP;
   endfunction

endpackage

// File: rtl/alu_mult_seq_if.sv
// EX-stage request/response bundle between the pipeline and the sequential multiplier.
interface alu_mult_seq_if #(
   parameter int DATA_W = 32
);

   logic [3:0]        alu_control;
   logic              start;
   logic              flush;
   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;
   logic              stall;
   logic              done;
   logic [DATA_W-1:0] result_lo;
   logic [DATA_W-1:0] result_hi;

   modport master (
      output alu_control, start, flush, operand_a, operand_b,
      input  stall, done, result_lo, result_hi
   );

   modport slave (
      input  alu_control, start, flush, operand_a, operand_b,
      output stall, done, result_lo, result_hi
   );

endinterface

// File: rtl/alu_mult_seq.sv
// Radix-2 shift-add unsigned multiplier: DATA_W iterations, stalls EX while busy,
// then presents the 2*DATA_W-bit product with a one-cycle done pulse.
module alu_mult_seq
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic          clk,
   input  logic          rst,
   alu_mult_seq_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   mult_state_e         state;
   mult_state_e         state_nxt;
   logic                fire;
   logic                load;
   logic                last;
   logic [2*DATA_W-1:0] mcand;
   logic [2*DATA_W-1:0] prod;
   logic [2*DATA_W-1:0] prod_nxt;
   logic [DATA_W-1:0]   mplier;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   res_lo;
   logic [DATA_W-1:0]   res_hi;
   logic                stall;
   logic                done;

   assign fire     = bus.start && is_mult(bus.alu_control) && !bus.flush;
   assign load     = fire && (state == IDLE || state == DONE);
   assign last     = (cnt == CNT_LAST);
   assign prod_nxt = mplier[0] ? prod + mcand : prod;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (fire) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    state_nxt = fire ? BUSY : IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // A new request in DONE keeps the pipeline frozen so the next product starts at once.
   always_comb begin
      stall = 1'b0;
      done  = 1'b0;
      case (state)
         IDLE: stall = fire;
         BUSY: stall = 1'b1;
         DONE: begin
            done  = 1'b1;
            stall = fire;
         end
         default: begin
            stall = 1'b0;
            done  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         cnt    <= '0;
         res_lo <= '0;
         res_hi <= '0;
      end else if (load) begin
         mcand  <= {{DATA_W{1'b0}}, bus.operand_a};
         mplier <= bus.operand_b;
         prod   <= '0;
         cnt    <= '0;
      end else if (state == BUSY && !bus.flush) begin
         prod   <= prod_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CNT_W'(1);
         // Capture includes the final partial product, so results never lag a cycle.
         if (last) begin
            res_lo <= prod_nxt[DATA_W-1:0];
            res_hi <= prod_nxt[2*DATA_W-1:DATA_W];
         end
      end
   end

   assign bus.stall     = stall;
   assign bus.done      = done;
   assign bus.result_lo = res_lo;
   assign bus.result_hi = res_hi;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a product scoreboard checked on every done pulse.
module tb_alu_mult_seq;
   import alu_pkg::*;

   localparam int DATA_W = 32;

   logic clk;
   logic rst;

   alu_mult_seq_if #(.DATA_W(DATA_W)) bus ();

   alu_mult_seq #(.DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   logic [63:0] last_prod = 64'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      return {32'd0, a} * {32'd0, b};
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", {63'd0, bus.done}, 64'd0);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("product", {bus.result_hi, bus.result_lo}, e);
            last_prod = e;
         end
      end
   end

   task automatic fire_mult(input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      bus.alu_control = MULT_OP;
      bus.start       = 1'b1;
      bus.flush       = 1'b0;
      bus.operand_a   = a;
      bus.operand_b   = b;
      exp_q.push_back(ref_mul(a, b));
      @(negedge clk);
      check("stall_on_fire", {63'd0, bus.stall}, 64'd1);
   endtask

   task automatic wait_done(input string tag, input int inj, input bit chain,
                            input logic [31:0] na, input logic [31:0] nb);
      int lat = 0;
      int busy_stall = 0;
      bit seen = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (lat == inj) begin
            bus.start       = 1'b1;
            bus.alu_control = MULT_OP;
            bus.operand_a   = 32'd100;
            bus.operand_b   = 32'd100;
         end
         @(negedge clk);
         lat++;
         if (bus.done === 1'b1) seen = 1'b1;
         else if (bus.stall === 1'b1) busy_stall++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd33);
      check({tag, "_busy_stall"}, 64'(busy_stall), 64'd32);
      check({tag, "_done_stall"}, {63'd0, bus.stall}, 64'd0);
      if (chain) begin
         bus.start       = 1'b1;
         bus.alu_control = MULT_OP;
         bus.operand_a   = na;
         bus.operand_b   = nb;
         exp_q.push_back(ref_mul(na, nb));
         #1;
         check({tag, "_chain_stall"}, {63'd0, bus.stall}, 64'd1);
      end
   endtask

   task automatic idle_cycles(input int n, output int stall_seen);
      stall_seen = 0;
      repeat (n) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         @(negedge clk);
         if (bus.stall === 1'b1) stall_seen++;
      end
   endtask

   initial begin
      int n_st;
      logic [31:0] ra;
      logic [31:0] rb;

      rst             = 1'b1;
      bus.start       = 1'b0;
      bus.flush       = 1'b0;
      bus.alu_control = ADD_OP;
      bus.operand_a   = '0;
      bus.operand_b   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", {63'd0, bus.stall}, 64'd0);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      check("rst_result", {bus.result_hi, bus.result_lo}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      fire_mult(32'd3, 32'd5);
      wait_done("basic", -1, 1'b0, '0, '0);
      @(negedge clk);
      check("done_one_cycle", {63'd0, bus.done}, 64'd0);
      check("basic_hold_lo", {32'd0, bus.result_lo}, 64'd15);

      fire_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("max", -1, 1'b0, '0, '0);
      fire_mult(32'd0, 32'd12345);
      wait_done("zero_a", -1, 1'b0, '0, '0);
      fire_mult(32'd777, 32'd0);
      wait_done("zero_b", -1, 1'b0, '0, '0);
      fire_mult(32'h8000_0000, 32'd2);
      wait_done("msb", -1, 1'b0, '0, '0);

      // Non-MULT code must be invisible to the multiplier.
      @(posedge clk); #1;
      bus.alu_control = ADD_OP;
      bus.start       = 1'b1;
      bus.operand_a   = 32'd7;
      bus.operand_b   = 32'd9;
      @(negedge clk);
      check("nonmult_stall", {63'd0, bus.stall}, 64'd0);
      idle_cycles(40, n_st);
      check("nonmult_stall_later", 64'(n_st), 64'd0);
      check("nonmult_results_hold", {bus.result_hi, bus.result_lo}, 64'h1_0000_0000);

      fire_mult(32'h0000_DEAD, 32'h0000_BEEF);
      idle_cycles(9, n_st);
      @(posedge clk); #1;
      bus.flush = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      check("flush_busy_stall", {63'd0, bus.stall}, 64'd1);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      check("flush_idle_stall", {63'd0, bus.stall}, 64'd0);
      idle_cycles(40, n_st);
      check("flush_no_restart", 64'(n_st), 64'd0);
      check("flush_results_hold", {bus.result_hi, bus.result_lo}, 64'h1_0000_0000);

      fire_mult(32'd1234, 32'd5678);
      wait_done("interfere", 5, 1'b1, 32'd6, 32'd7);
      wait_done("b2b", -1, 1'b0, '0, '0);
      check("b2b_lo", {32'd0, bus.result_lo}, 64'd42);

      @(posedge clk); #1;
      bus.alu_control = MULT_OP;
      bus.start       = 1'b1;
      bus.flush       = 1'b1;
      bus.operand_a   = 32'd9;
      bus.operand_b   = 32'd9;
      @(negedge clk);
      check("flush_start_stall", {63'd0, bus.stall}, 64'd0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      check("flush_start_noop", {63'd0, bus.stall}, 64'd0);
      idle_cycles(40, n_st);
      check("flush_start_quiet", 64'(n_st), 64'd0);

      for (int i = 0; i < 3; i++) begin
         ra = $urandom;
         rb = $urandom;
         fire_mult(ra, rb);
         wait_done("random", -1, 1'b0, '0, '0);
      end

      fire_mult(32'd55, 32'd66);
      idle_cycles(9, n_st);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_stall", {63'd0, bus.stall}, 64'd0);
      check("midrst_done", {63'd0, bus.done}, 64'd0);
      check("midrst_result", {bus.result_hi, bus.result_lo}, 64'd0);
      idle_cycles(40, n_st);
      check("midrst_quiet", 64'(n_st), 64'd0);

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Multi-cycle radix-2 shift-add multiplier; the execute-stage consumer of the MULT code emitted by ALU control.
- Sits beside the combinational ALU in EX. On a MULT request it stalls the pipeline until a full 2*DATA_W-bit product is ready, then releases it with a one-cycle done pulse.
- Unsigned product; the low word is the RV32M MUL result.

Parameters:
- DATA_W, 32, operand width; product is 2*DATA_W.
- CNT_W, $clog2(DATA_W)+1, iteration counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- alu_control  in  4  operation code from ALU control.
- start  in  1  EX-stage instruction valid.
- flush  in  1  kill in-flight operation (branch mispredict / exception).
- operand_a  in  DATA_W  multiplicand.
- operand_b  in  DATA_W  multiplier.
- stall  out  1  freeze IF/ID/EX (combinational).
- done  out  1  one-cycle pulse; product valid.
- result_lo  out  DATA_W  product[DATA_W-1:0].
- result_hi  out  DATA_W  product[2*DATA_W-1:DATA_W].

Behaviour:
- Reset: state=IDLE. done=0, stall=0, result_lo=0, result_hi=0, counter=0, internal regs=0. Reset overrides everything, including mid-operation.
- fire = start && (alu_control==MULT_OP) && !flush. Other alu_control values are ignored entirely.
- States:
  - IDLE: fire -> BUSY. Load mcand={DATA_W'0,operand_a}, mplier=operand_b, prod=0, cnt=0.
  - BUSY, each cycle:
    - if mplier[0], prod <= prod + mcand (2*DATA_W wide, carry discarded beyond 2*DATA_W; cannot overflow);
    - mcand <<= 1; mplier >>= 1; cnt++.
    - When cnt reaches DATA_W-1 on this cycle's update -> DONE. Results register the final prod.
  - DONE: done=1 for exactly this cycle.
    - fire -> BUSY (back-to-back, reload as in IDLE);
    - else -> IDLE.
- Fixed latency, no early termination:
  - fire sampled at edge E0;
  - DATA_W BUSY cycles;
  - done high in the cycle after the last BUSY cycle, i.e. DATA_W+1 cycles after E0.
- stall = (state==IDLE && fire) || (state==BUSY) || (state==DONE && fire). Low in a DONE cycle with no new request, so the pipeline advances and captures result_lo/hi.
- result_lo/hi update only on the BUSY->DONE transition. They hold their value until the next completion; they do not clear in IDLE.
- start/operands during BUSY are ignored; the loaded copies are used.
- flush in any state -> IDLE next edge:
  - no done pulse;
  - results unchanged;
  - stall deasserts combinationally in the flush cycle when state is IDLE/DONE, next cycle when state is BUSY.
- flush and start asserted together: flush wins, nothing accepted.
- Operand 0 on either side: still full latency, product 0.

Decomposition:
- Shared package alu_pkg:
  - ALU control codes AND_OP=0, OR_OP=1, ADD_OP=2, SLL_OP=3, SRL_OP=4, SUB_OP=6, SLT_OP=7, MULT_OP=8 (distinct from SLT);
  - ALUOP codes;
  - mult state enum {IDLE, BUSY, DONE}.
- ALU control and ALU import the same package so the MULT code is defined once.
- No sub-module; datapath and FSM stay in one file.

Test Plan (DATA_W=32):
- Basic: a=3, b=5, alu_control=MULT_OP, start one cycle -> stall high 33 cycles, done pulses at cycle 33, result_lo=15, result_hi=0, stall low in the done cycle.
- Max operands: a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001. Also a=0x80000000, b=2 -> hi=1, lo=0.
- Non-MULT: start with alu_control=ADD_OP, a=7, b=9 -> stall never asserts, done never pulses, results keep prior value.
- Flush/reset mid-op: fire, flush at cycle 10 -> IDLE next edge, no done, results retain previous product. Repeat with rst at cycle 10 -> all outputs 0.
- Busy interference and back-to-back:
  - during BUSY drive start with a=100, b=100 -> ignored, first product correct;
  - hold start with new MULT (a=6, b=7) in the DONE cycle -> stall stays high, second done 33 cycles later with lo=42.
- Flush+start same cycle in IDLE -> no operation starts, stall low.
